face_coords_uart_tx: RTL and testbench
======================================

# face_coords_uart_tx

Serializes detected face bounding boxes from the Viola-Jones pipeline back to the laptop over a UART line. This is the return direction of the link that delivers the 320x240 image. Each cycle with `face_coords_ready` high queues one detection in a small FIFO, and an end-of-frame request queues a marker behind it. A framed 8N1 byte serializer drains the queue as fixed 10-byte packets.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200).
- `FIFO_DEPTH`, default 4: number of queued entries (power of two, ≥2).
- `clock`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `face_coords`  in  [3:0][31:0]  order {col_right, col_left, row_bottom, row_top}; index 0 = row_top.
- `face_coords_ready`  in  1  one detection per cycle high.
- `frame_done`  in  1  one-cycle pulse; queue end-of-frame marker.
- `tx`  out  1  UART line, idle high.
- `busy`  out  1  FIFO non-empty, marker pending, or serializer active.
- `overflow`  out  1  sticky; a detection was dropped.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupied entries.

## Operation
- FIFO entry: four 16-bit coordinates (low 16 bits of each `face_coords` word) plus a marker flag.
- Push on detection: when `face_coords_ready` is high and the FIFO is not full, write the entry at the clock edge.
  - When the FIFO is full, drop the detection and set `overflow`.
  - When the FIFO is full but a pop happens in the same cycle, accept the push.
- Marker: `frame_done` sets `marker_pending`.
  - The marker is written on the first cycle with no detection push and the FIFO not full, or full with a pop that cycle; that cycle clears `marker_pending`.
  - A marker never overtakes earlier detections.
  - A `frame_done` arriving while already pending is merged into the existing pending marker.
- Face packet, 10 bytes: 0xFA; row_top lo, hi; row_bottom lo, hi; col_left lo, hi; col_right lo, hi; then checksum = XOR of bytes 1-8.
- Marker packet: a single byte 0xFE.
- Packet FSM states:
  - IDLE: if the FIFO is non-empty, pop the head and latch it into the packet register → SEND.
  - SEND: hand the current byte to the serializer and wait for it to finish. byte_idx runs 0..9 for a face and 0 only for a marker. After the last byte → IDLE.
- Byte serializer states:
  - IDLE: `tx` = 1.
  - START: `tx` = 0.
  - DATA: 8 bits, LSB first.
  - STOP: `tx` = 1.
  - Each state lasts exactly CLKS_PER_BIT cycles per bit.

## Timing
- Reset values: `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0; FIFO and `marker_pending` cleared.
- Reset asserted mid-packet: `tx` goes high immediately and the partial byte is abandoned.
- Latency, from the idle state: detection sampled at edge N → entry visible at N+1 → `tx` falls (start bit) at edge N+2.
- Byte period is 10·CLKS_PER_BIT cycles. A face packet occupies 100·CLKS_PER_BIT cycles on the line.
- Consecutive bytes and consecutive packets are back-to-back: the next start bit immediately follows a full stop bit, with no extra idle cycles.
- `fifo_count` updates on the edge of each push and pop; it is unchanged on a simultaneous push and pop.
- `busy` deasserts on the cycle after the final stop bit completes when nothing is queued.

## Structure
- Package `face_tx_pkg` holds:
  - constants `FACE_HDR`=8'hFA, `EOF_HDR`=8'hFE, `FACE_PKT_BYTES`=10;
  - typedef `face_entry_t` (marker flag + four 16-bit coordinates).
- Sub-module `uart_tx_byte`: `clock`, `reset_n`, `data[7:0]`, `valid`/`ready` handshake, `tx`. Parameter CLKS_PER_BIT.
  - `ready` is high only in IDLE.
  - A byte is accepted on `valid && ready`.
- The top block contains the FIFO, the `marker_pending` register, the packet FSM and checksum accumulation.

## Test plan
- Single face, with CLKS_PER_BIT=4: coords {row_top 10, row_bottom 33, col_left 20, col_right 43} → line carries FA 0A 00 21 00 14 00 2B 00 14 LSB-first. Start bit at edge N+2; 400 cycles total.
- Face then `frame_done` in the same cycle → face packet is sent, then 0xFE immediately after, with no gap.
- Six consecutive detections with FIFO_DEPTH=4, line idle → `fifo_count` peaks at 4, one detection dropped, `overflow`=1. The first five packets are sent in order.
- `frame_done` alone while idle → single 0xFE frame: tx low for 4 cycles, bits 0,1,1,1,1,1,1,1, then stop bit.
- `reset_n` asserted mid-byte 3 → `tx`=1 at once, FIFO empty. After release with no input, `tx` stays high for ≥1000 cycles.
- Detection with coords above 16 bits (row_top 32'h0001_0005) → bytes 05 00 transmitted; upper bits are truncated.

Source files
------------

// File: rtl/face_tx_pkg.sv
// Shared constants and types for the face-coordinate UART return link.
package face_tx_pkg;

  localparam logic [7:0] FACE_HDR       = 8'hFA;
  localparam logic [7:0] EOF_HDR        = 8'hFE;
  localparam int         FACE_PKT_BYTES = 10;

  // One queued item: a detection box or an end-of-frame marker.
  typedef struct packed {
    logic        marker;
    logic [15:0] col_right;
    logic [15:0] col_left;
    logic [15:0] row_bottom;
    logic [15:0] row_top;
  } face_entry_t;

  typedef enum logic {PKT_IDLE, PKT_SEND} pkt_state_t;

  typedef enum logic [1:0] {SER_IDLE, SER_START, SER_DATA, SER_STOP} ser_state_t;

  // Byte idx of the packet built from entry e; csum is the running XOR of bytes 1..8.
  function automatic logic [7:0] pkt_byte(face_entry_t e, logic [3:0] idx, logic [7:0] csum);
    // NOTE: every path of a combinational case must assign, so the default arm is what keeps this latch-free.
    case (idx)
      4'd0:    pkt_byte = e.marker ? EOF_HDR : FACE_HDR;
      4'd1:    pkt_byte = e.row_top[7:0];
      4'd2:    pkt_byte = e.row_top[15:8];
      4'd3:    pkt_byte = e.row_bottom[7:0];
      4'd4:    pkt_byte = e.row_bottom[15:8];
      4'd5:    pkt_byte = e.col_left[7:0];
      4'd6:    pkt_byte = e.col_left[15:8];
      4'd7:    pkt_byte = e.col_right[7:0];
      4'd8:    pkt_byte = e.col_right[15:8];
      default: pkt_byte = csum;
    endcase
  endfunction

endpackage

// File: rtl/face_coords_uart_tx_if.sv
// Detection input bundle from the Viola-Jones pipeline.
interface face_coords_uart_tx_if;
  logic [3:0][31:0] face_coords;
  logic             face_coords_ready;
  logic             frame_done;

  modport master (output face_coords, face_coords_ready, frame_done);
  modport slave  (input  face_coords, face_coords_ready, frame_done);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. The IDLE cycle doubles as the final stop-bit cycle so a
// byte offered while idle starts exactly one full stop bit after the previous one.
module uart_tx_byte
  import face_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int             CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  STOP_LAST = CW'(CLKS_PER_BIT - 2);

  ser_state_t    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    data_q;

  assign ready = (state == SER_IDLE);

  // Bit timing and line driver; tx is registered so it never glitches.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= SER_IDLE;
      tx      <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        SER_IDLE: begin
          tx <= 1'b1;
          if (valid) begin
            data_q <= data;
            tx     <= 1'b0;
            cnt    <= '0;
            state  <= SER_START;
          end
        end
        SER_START: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= data_q[0];
            state   <= SER_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SER_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= (CLKS_PER_BIT == 1) ? SER_IDLE : SER_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= data_q[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == STOP_LAST) state <= SER_IDLE;
          else                  cnt   <= cnt + 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/face_coords_uart_tx.sv
// Queues detections and end-of-frame markers, then frames them as packets over UART.
module face_coords_uart_tx
  import face_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  face_coords_uart_tx_if.slave          det,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);

  face_entry_t mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          marker_pending;
  face_entry_t   wr_entry;
  logic          full, pop, push_det, push_mark, push;

  pkt_state_t  pkt_state;
  face_entry_t pkt;
  logic [3:0]  byte_idx;
  logic [7:0]  csum, cur_byte;
  logic        ser_valid, ser_ready;
  logic        busy_c, busy_q;

  // Only the low 16 bits of each coordinate are carried on the link.
  logic unused_hi;
  assign unused_hi = ^{det.face_coords[3][31:16], det.face_coords[2][31:16],
                       det.face_coords[1][31:16], det.face_coords[0][31:16]};

  assign full      = (fifo_count == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
  assign pop       = (pkt_state == PKT_IDLE) && (fifo_count != '0);
  assign push_det  = det.face_coords_ready && (!full || pop);
  // A detection always wins the write slot, so a marker cannot overtake it.
  assign push_mark = marker_pending && !det.face_coords_ready && (!full || pop);
  assign push      = push_det || push_mark;

  // Assemble the entry written this cycle.
  always_comb begin
    wr_entry            = '0;
    wr_entry.marker     = push_mark;
    wr_entry.row_top    = det.face_coords[0][15:0];
    wr_entry.row_bottom = det.face_coords[1][15:0];
    wr_entry.col_left   = det.face_coords[2][15:0];
    wr_entry.col_right  = det.face_coords[3][15:0];
  end

  // FIFO storage.
  // NOTE: the storage array is not reset; the cleared pointers and count already make it empty.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // FIFO pointers, occupancy, overflow flag and pending end-of-frame marker.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      overflow       <= 1'b0;
      marker_pending <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (det.face_coords_ready && full && !pop) overflow <= 1'b1;
      // A repeat frame_done while pending merges into the marker already owed.
      marker_pending <= (marker_pending && !push_mark) || (det.frame_done && !marker_pending);
    end
  end

  assign cur_byte  = pkt_byte(pkt, byte_idx, csum);
  assign ser_valid = (pkt_state == PKT_SEND);

  // Packet FSM: pop one entry, feed its bytes to the serializer, fold the checksum.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pkt_state <= PKT_IDLE;
      pkt       <= '0;
      byte_idx  <= '0;
      csum      <= '0;
    end else begin
      case (pkt_state)
        PKT_IDLE: begin
          if (pop) begin
            pkt       <= mem[rd_ptr];
            byte_idx  <= '0;
            csum      <= '0;
            pkt_state <= PKT_SEND;
          end
        end
        default: begin
          if (ser_ready) begin
            if (byte_idx != 4'd0) csum <= csum ^ cur_byte;
            if (pkt.marker || byte_idx == 4'(FACE_PKT_BYTES - 1)) pkt_state <= PKT_IDLE;
            else                                                   byte_idx  <= byte_idx + 4'd1;
          end
        end
      endcase
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clock   (clock),
    .reset_n (reset_n),
    .data    (cur_byte),
    .valid   (ser_valid),
    .ready   (ser_ready),
    .tx      (tx)
  );

  // The serializer's IDLE overlaps the last stop-bit cycle; busy_q stretches busy across it.
  assign busy_c = (fifo_count != '0) || marker_pending || (pkt_state == PKT_SEND) || !ser_ready;
  assign busy   = busy_c || busy_q;

  // One-cycle stretch of the activity term.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy_q <= 1'b0;
    else          busy_q <= busy_c;
  end

endmodule

// File: tb/tb_face_coords_uart_tx.sv
// Scoreboard bench: stimulus pushes expected bytes, a UART line decoder pops and compares.
module tb_face_coords_uart_tx;
  import face_tx_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int BYTE_CYC = 10 * CPB;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic tx, busy, overflow;
  logic [CW-1:0] fifo_count;

  face_coords_uart_tx_if det_if();

  face_coords_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .det        (det_if),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         max_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference model: a face packet is header, eight little-endian coordinate bytes, XOR of those eight.
  task automatic model_face(input logic [3:0][31:0] c);
    logic [7:0] x;
    logic [15:0] v;
    x = 8'h00;
    exp_q.push_back(8'hFA);
    for (int w = 0; w < 4; w++) begin
      v = c[w][15:0];
      exp_q.push_back(v[7:0]);
      exp_q.push_back(v[15:8]);
      x = x ^ v[7:0] ^ v[15:8];
    end
    exp_q.push_back(x);
  endtask

  // Line decoder: 40 samples per byte, one per cycle on the falling clock edge.
  logic        rx_active = 1'b0;
  int          rx_k = 0;
  logic [39:0] rx_s;
  always @(negedge clock) begin
    if (!reset_n) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx == 1'b0) begin
        rx_active = 1'b1;
        rx_s      = '0;
        rx_k      = 1;
        start_q.push_back(cyc);
      end
    end else begin
      rx_s[rx_k] = tx;
      rx_k++;
      if (rx_k == BYTE_CYC) begin
        logic ok;
        logic [7:0] b;
        rx_active = 1'b0;
        ok = (rx_s[3:0] == 4'h0) && (rx_s[39:36] == 4'hF);
        for (int i = 0; i < 8; i++) begin
          b[i] = rx_s[4 + 4*i];
          if (rx_s[4+4*i +: 4] != {4{b[i]}}) ok = 1'b0;
        end
        check("uart_framing", ok, 1'b1);
        check("byte_was_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("tx_byte", b, exp_q.pop_front());
      end
    end
  end

  always @(negedge clock) if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);

  task automatic check_spacing(input string name, input int n);
    logic ok;
    ok = (start_q.size() == n);
    for (int i = 1; i < start_q.size(); i++)
      if (start_q[i] - start_q[i-1] != BYTE_CYC) ok = 1'b0;
    check(name, ok, 1'b1);
  endtask

  // Consecutive detections from an idle line; the first five fit (four queued plus one popped).
  task automatic drive_burst(input int k, input bit fd_last, input bit use_first,
                             input logic [3:0][31:0] first_c, output int n_first);
    logic [3:0][31:0] c;
    n_first = 0;
    for (int i = 0; i < k; i++) begin
      @(negedge clock);
      c = {$urandom, $urandom, $urandom, $urandom};
      if (i == 0 && use_first) c = first_c;
      det_if.face_coords       = c;
      det_if.face_coords_ready = 1'b1;
      det_if.frame_done        = fd_last && (i == k - 1);
      if (i == 0) n_first = cyc + 1;
      if (i < DEPTH + 1) model_face(c);
    end
    @(negedge clock);
    det_if.face_coords_ready = 1'b0;
    det_if.frame_done        = 1'b0;
    if (fd_last) exp_q.push_back(8'hFE);
  endtask

  task automatic drive_frame_done();
    @(negedge clock);
    det_if.frame_done = 1'b1;
    @(negedge clock);
    det_if.frame_done = 1'b0;
    exp_q.push_back(8'hFE);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    @(negedge clock);
    while ((busy || rx_active) && t < 6000) begin
      @(negedge clock);
      t++;
    end
    check({name, "_drained"}, t < 6000, 1'b1);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [3:0][31:0] c;
    int n, lows, k;
    bit fd;

    det_if.face_coords       = '0;
    det_if.face_coords_ready = 1'b0;
    det_if.frame_done        = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    check("reset_fifo_count", fifo_count, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Single face with literal expected bytes, latency and busy tail.
    start_q.delete();
    @(negedge clock);
    c[0] = 32'd10; c[1] = 32'd33; c[2] = 32'd20; c[3] = 32'd43;
    det_if.face_coords       = c;
    det_if.face_coords_ready = 1'b1;
    n = cyc + 1;
    @(negedge clock);
    det_if.face_coords_ready = 1'b0;
    check("single_count_after_push", fifo_count, 1);
    check("single_busy_early", busy, 1'b1);
    foreach (c[i]) c[i] = 32'h0;
    exp_q.push_back(8'hFA); exp_q.push_back(8'h0A); exp_q.push_back(8'h00);
    exp_q.push_back(8'h21); exp_q.push_back(8'h00); exp_q.push_back(8'h14);
    exp_q.push_back(8'h00); exp_q.push_back(8'h2B); exp_q.push_back(8'h00);
    exp_q.push_back(8'h14);
    while (cyc < n + 100*CPB + 1) @(negedge clock);
    check("single_busy_last_stop", busy, 1'b1);
    @(negedge clock);
    check("single_busy_done", busy, 1'b0);
    check("single_start_latency", start_q.size() > 0 ? start_q[0] - n : -1, 2);
    check_spacing("single_spacing", 10);
    check("single_queue_empty", exp_q.size(), 0);

    // Face and frame_done together: marker follows with no gap.
    start_q.delete();
    drive_burst(1, 1'b1, 1'b0, '0, n);
    wait_idle("face_marker");
    check_spacing("face_marker_spacing", 11);
    check("no_overflow_yet", overflow, 1'b0);

    // Six detections into a depth-4 FIFO: one dropped.
    start_q.delete();
    max_cnt = 0;
    drive_burst(6, 1'b0, 1'b0, '0, n);
    wait_idle("burst6");
    check("burst6_peak_count", max_cnt, DEPTH);
    check("burst6_overflow", overflow, 1'b1);
    check_spacing("burst6_spacing", 50);

    // Lone end-of-frame marker.
    start_q.delete();
    drive_frame_done();
    wait_idle("marker_only");
    check("marker_only_bytes", start_q.size(), 1);

    // Reset in the middle of byte 3 while a second face waits in the FIFO.
    drive_burst(2, 1'b0, 1'b0, '0, n);
    while (cyc < n + 2 + 3*BYTE_CYC + 18) @(negedge clock);
    check("pre_reset_count", fifo_count, 1);
    reset_n = 1'b0;
    #1;
    check("mid_reset_tx", tx, 1'b1);
    check("mid_reset_count", fifo_count, 0);
    check("mid_reset_busy", busy, 1'b0);
    check("mid_reset_overflow", overflow, 1'b0);
    repeat (3) @(negedge clock);
    exp_q.delete();
    start_q.delete();
    reset_n = 1'b1;
    lows = 0;
    repeat (1000) begin
      @(negedge clock);
      if (tx !== 1'b1) lows++;
    end
    check("post_reset_line_idle", lows, 0);
    check("post_reset_no_bytes", start_q.size(), 0);

    // Coordinates wider than 16 bits are truncated.
    c = {$urandom, $urandom, $urandom, 32'h0001_0005};
    drive_burst(1, 1'b0, 1'b1, c, n);
    wait_idle("truncate");

    // Randomised bursts and markers from an idle line.
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        drive_frame_done();
        wait_idle("rand_marker");
      end
      k  = $urandom_range(1, DEPTH + 1);
      fd = bit'($urandom_range(0, 1));
      drive_burst(k, fd, 1'b0, '0, n);
      wait_idle("rand_burst");
    end
    check("rand_no_overflow", overflow, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
